// File: rtl/hwpe_stream_package.sv
// Shared HWPE stream types: realigner control structs and the source-realigner FSM state.
package hwpe_stream_package;

    typedef struct packed {
        logic       enable;
        logic       strb_valid;
        logic [7:0] offset;
    } ctrl_realign_t;

    // Field widths cover the largest supported stream; modules use the low bits they need.
    typedef struct packed {
        logic        start;
        logic [7:0]  offset;
        logic [31:0] n_words;
    } ctrl_source_realign_t;

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_PRIME,
        SRC_STEADY,
        SRC_DONE
    } source_realign_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready byte-strobed stream interface used between HWPE streamer stages.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_source_realign_slice.sv
// Two-entry elastic output slice: full throughput under continuous ready, no valid-to-ready path.
module hwpe_stream_source_realign_slice #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [DATA_WIDTH/8-1:0] out_strb,
    output logic                    empty
);
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            cnt_q;
    logic                  push;
    logic                  pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign empty     = (cnt_q == 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_strb  = out_valid ? '1 : '0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    mem_q[gi] <= '0;
                end else if (clear_i) begin
                    mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    mem_q[gi] <= in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/hwpe_stream_source_realign.sv
// Load-path realigner: turns words fetched from a misaligned address into an aligned stream.
// Optional output register slice: define HWPE_STREAM_SOURCE_REALIGN_OUTREG_EN.
module hwpe_stream_source_realign
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  ctrl_source_realign_t   ctrl_i,
    output logic                   busy_o,
    output logic                   done_o,
    hwpe_stream_intf_stream.sink   stream_i,
    hwpe_stream_intf_stream.source stream_o
);
    localparam int unsigned BW = DATA_WIDTH / 8;
    localparam int unsigned OW = (BW > 1) ? $clog2(BW) : 1;
    localparam int unsigned SW = OW + 3;

    source_realign_state_t state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [OW-1:0]         offset_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] realigned;
    logic [SW-1:0]         sh_lo;
    logic [SW-1:0]         sh_hi;
    logic                  core_valid;
    logic                  core_ready;
    logic                  push;
    logic                  in_hs;
    logic                  steady_exit;
    logic                  unused_bits;

    assign unused_bits = ^{ctrl_i.offset, ctrl_i.n_words, stream_i.strb};

    // 8*BW wraps to zero on SW bits, so sh_hi is exactly 8*(BW-offset) for every non-zero offset.
    assign sh_lo = {offset_q, 3'b000};
    assign sh_hi = SW'(DATA_WIDTH) - sh_lo;

    always_comb begin
        realigned = stream_i.data;
        if (offset_q != '0) begin
            realigned = (prev_q >> sh_lo) | (stream_i.data << sh_hi);
        end
    end

    assign push  = core_valid && core_ready;
    assign in_hs = stream_i.valid && stream_i.ready;

`ifdef HWPE_STREAM_SOURCE_REALIGN_OUTREG_EN
    logic slice_empty;

    hwpe_stream_source_realign_slice #(
        .DATA_WIDTH (DATA_WIDTH)
    ) i_slice (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .in_valid  (core_valid),
        .in_ready  (core_ready),
        .in_data   (realigned),
        .out_valid (stream_o.valid),
        .out_ready (stream_o.ready),
        .out_data  (stream_o.data),
        .out_strb  (stream_o.strb),
        .empty     (slice_empty)
    );

    // Stay in STEADY after the last push until the slice has handed everything downstream.
    assign steady_exit = (cnt_q == '0) && slice_empty;
`else
    assign core_ready     = stream_o.ready;
    assign stream_o.valid = core_valid;
    assign stream_o.data  = (state_q == SRC_STEADY) ? realigned : '0;
    assign stream_o.strb  = (state_q == SRC_STEADY) ? '1 : '0;
    assign steady_exit    = push && (cnt_q == CNT_WIDTH'(1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SRC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SRC_IDLE: begin
                if (ctrl_i.start) begin
                    if (ctrl_i.n_words[CNT_WIDTH-1:0] == '0)  state_d = SRC_DONE;
                    else if (ctrl_i.offset[OW-1:0] == '0)     state_d = SRC_STEADY;
                    else                                      state_d = SRC_PRIME;
                end
            end
            SRC_PRIME:  if (in_hs)       state_d = SRC_STEADY;
            SRC_STEADY: if (steady_exit) state_d = SRC_DONE;
            SRC_DONE:                    state_d = SRC_IDLE;
            default:                     state_d = SRC_IDLE;
        endcase
        if (clear_i) state_d = SRC_IDLE;
    end

    // Handshakes are suppressed during a clear so no word is consumed by a transfer being dropped.
    always_comb begin
        busy_o         = (state_q != SRC_IDLE);
        done_o         = (state_q == SRC_DONE);
        stream_i.ready = 1'b0;
        core_valid     = 1'b0;
        unique case (state_q)
            SRC_PRIME: stream_i.ready = !clear_i;
            SRC_STEADY: begin
                core_valid     = stream_i.valid && (cnt_q != '0) && !clear_i;
                stream_i.ready = core_ready && (cnt_q != '0) && !clear_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            offset_q <= '0;
            prev_q   <= '0;
        end else if (clear_i) begin
            cnt_q    <= '0;
            offset_q <= '0;
            prev_q   <= '0;
        end else begin
            if ((state_q == SRC_IDLE) && ctrl_i.start) begin
                offset_q <= ctrl_i.offset[OW-1:0];
                cnt_q    <= ctrl_i.n_words[CNT_WIDTH-1:0];
            end else if (push) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
            if (in_hs) prev_q <= stream_i.data;
        end
    end

endmodule

// File: doc/hwpe_stream_source_realign.md
# hwpe_stream_source_realign

Read-side realigner for HWPE streamers. It consumes full memory words fetched from a start address that is not word-aligned and emits a word-aligned output stream, merging the upper bytes of each fetched word with the lower bytes of the next. It sits between the TCDM load FIFO and the consumer stream of a source streamer, and is the load-path counterpart of the store-path sink realigner.

## Interface
- `DATA_WIDTH`, default 32: stream width in bits. Must be a multiple of 8. `BW = DATA_WIDTH/8`, `OW = $clog2(BW)`.
- `CNT_WIDTH`, default 16: width of the output word counter.
- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `clear_i`, input, 1: synchronous soft clear back to IDLE.
- `ctrl_i`, input, `ctrl_source_realign_t`, with these fields:
  - `start`: 1-cycle start pulse.
  - `offset[OW-1:0]`: start byte lane in the first fetched word.
  - `n_words[CNT_WIDTH-1:0]`: number of aligned output words.
- `busy_o`, output, 1: high while not in IDLE.
- `done_o`, output, 1: 1-cycle pulse at the end of a transfer.
- `stream_i`, `hwpe_stream_intf_stream.sink`, `DATA_WIDTH`: raw fetched words.
- `stream_o`, `hwpe_stream_intf_stream.source`, `DATA_WIDTH`: aligned words.

## Operation
- Reset and clear values: state IDLE, counter 0, `prev_q` 0, `busy_o`=0, `done_o`=0, `stream_o.valid`=0, `stream_o.data`=0, `stream_o.strb`=0, `stream_i.ready`=0.
- The FSM has four states: IDLE, PRIME, STEADY and DONE.
  - **IDLE.** On `start`, latch `offset` and `n_words`.
    - `n_words`=0: go to DONE.
    - `offset`=0: go to STEADY.
    - Otherwise: go to PRIME.
  - **PRIME.** `stream_i.ready`=1 and `stream_o.valid`=0. On `stream_i` handshake, capture the data into `prev_q` and go to STEADY.
  - **STEADY, `offset`=0.** Pass-through: `stream_o.valid`=`stream_i.valid`, `stream_i.ready`=`stream_o.ready`, data is forwarded unchanged.
  - **STEADY, `offset`≠0.**
    - Data is `(prev_q >> 8*offset) | (stream_i.data << 8*(BW-offset))`.
    - `prev_q` is updated on each input handshake.
    - Valid and ready are coupled as in pass-through.
  - **STEADY, both cases.** `stream_o.strb` is all ones. Each output handshake decrements the counter; the handshake that brings it to 0 moves the FSM to DONE.
  - **DONE.** `done_o`=1 for exactly one cycle, then go to IDLE.
- Input word count per transfer is `n_words` when `offset`=0, otherwise `n_words+1`. Input bytes beyond the last needed byte are discarded.
- Shift amounts are computed on `OW+3` bits. `8*(BW-offset)` is never evaluated when `offset`=0.
- `start` outside IDLE is ignored.
- `clear_i` has priority over `start` and over every state transition. Assertion of `rst_i` at any point, including mid-transfer, returns the block to its reset values immediately.
- `stream_o.valid` never depends on `stream_o.ready`. Once `stream_o.valid` is asserted, data and valid stay stable until the handshake.

## Timing
- Output latency after `start` without the output register:
  - `offset`=0: first output word is visible combinationally in the first STEADY cycle.
  - `offset`≠0: the first output needs two input handshakes.
- Throughput is one word per cycle in STEADY. PRIME adds one input-only cycle.
- `done_o` is asserted in the cycle after the final output handshake. `busy_o` falls in the cycle after that.
- `n_words`=0: `done_o` is high in cycle start+1, and no `stream_i` or `stream_o` handshakes occur.

## Configuration
- `HWPE_STREAM_SOURCE_REALIGN_OUTREG_EN` defined:
  - `stream_o` is driven by a 2-entry elastic register slice.
  - Adds one cycle of latency; throughput stays one word per cycle under continuous ready.
  - `stream_i.ready` is driven by slice-not-full instead of `stream_o.ready`.
  - `done_o` waits until the slice has drained.
- Macro undefined: the datapath is purely combinational from `stream_i` to `stream_o`, as described above.

## Structure
- `ctrl_source_realign_t` and the FSM state enum live in `hwpe_stream_package`, next to `ctrl_realign_t`.
- The output slice is the sub-module `hwpe_stream_source_realign_slice`, instantiated only under the macro.

## Test plan
All scenarios use `DATA_WIDTH`=32. Input words are `0x33221100`, `0x77665544`, `0xBBAA9988`.
- **Misaligned, offset 1.** `offset`=1, `n_words`=2, all three words -> outputs `0x44332211`, `0x88776655`; `done_o` pulses once; exactly 3 input handshakes.
- **Aligned pass-through.** `offset`=0, `n_words`=2 -> outputs `0x33221100`, `0x77665544`; exactly 2 input handshakes; `strb`=`0xF`.
- **Offset 3 with stalls.** `offset`=3, `n_words`=2, with `stream_o.ready` toggled 1,0,0,1 -> outputs `0x66554433`, `0xAA998877`; data held stable while stalled.
- **Empty transfer.** `n_words`=0 -> `done_o` high in cycle start+1; no stream activity.
- **Clear mid-transfer.** `clear_i` in STEADY after 1 output, then a new `start` with `offset`=2, `n_words`=1 -> clean restart; output `0x55443322`.
- **Reset mid-transfer.** `rst_i` pulsed mid-transfer -> all outputs 0 in the same cycle; `start` pulsed during `busy_o` is ignored.
